// File: rtl/ternary_stream_driver_pkg.sv
// Shared constants, state encoding and command-word helper for the ternary
// mat-vec core stream driver.
package ternary_pkg;

    localparam int IN_LEN    = 16;
    localparam int OUT_LEN   = 8;
    localparam int RES_LAT   = 2;
    localparam int WORDS     = 2 * IN_LEN * OUT_LEN / 16;
    localparam int VEC_WORDS = IN_LEN / 2;
    localparam int WA_W      = $clog2(WORDS);
    localparam int CNT_W     = $clog2(WORDS) + 1;

    localparam logic [1:0] CMD_LOAD = 2'b10;
    localparam logic [1:0] CMD_MULT = 2'b11;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(VEC_WORDS - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RES_LAT - 2);
    localparam logic [CNT_W-1:0] CAPT_LAST = CNT_W'(OUT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RST  = 4'd1,
        S_CMD  = 4'd2,
        S_LOAD = 4'd3,
        S_FILL = 4'd4,
        S_SEND = 4'd5,
        S_WAIT = 4'd6,
        S_CAPT = 4'd7,
        S_FIN  = 4'd8
    } state_t;

    function automatic logic [15:0] cmd_word(input logic [1:0] cmd);
        cmd_word = {2'b00, cmd, 12'h000};
    endfunction

endpackage

// File: rtl/ternary_stream_driver_if.sv
// Host-side bus of the stream driver: job control, weight writes,
// activation stream, core word bus and result stream.
interface ternary_stream_driver_if;
    import ternary_pkg::*;

    logic              start;
    logic              mode_load;
    logic [7:0]        vec_count;
    logic              w_wr_en;
    logic [WA_W-1:0]   w_wr_addr;
    logic [15:0]       w_wr_data;
    logic              act_valid;
    logic              act_ready;
    logic [15:0]       act_data;
    logic [15:0]       drv_word;
    logic              dut_rst_n;
    logic [7:0]        res_in;
    logic              res_valid;
    logic [7:0]        res_data;
    logic              busy;
    logic              done;

    modport master (
        input  start, mode_load, vec_count, w_wr_en, w_wr_addr, w_wr_data,
        input  act_valid, act_data, res_in,
        output act_ready, drv_word, dut_rst_n, res_valid, res_data, busy, done
    );

    modport slave (
        output start, mode_load, vec_count, w_wr_en, w_wr_addr, w_wr_data,
        output act_valid, act_data, res_in,
        input  act_ready, drv_word, dut_rst_n, res_valid, res_data, busy, done
    );

endinterface

// File: rtl/ternary_stream_driver_vec_buf.sv
// Write-then-drain activation buffer holding one vector; the read word is
// presented combinationally so the driver can register it onto the core bus.
module ternary_vec_buf #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          wr_ok_s;
    logic          rd_ok_s;

    assign wr_ok_s = wr_en && !full;
    assign rd_ok_s = rd_en && !empty;
    assign full    = (level_r == LW'(DEPTH));
    assign empty   = (level_r == {LW{1'b0}});
    assign rd_data = mem_r[rd_ptr_r];

    // Storage array; contents need no reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and fill level; reset flushes the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= (wr_ptr_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/ternary_stream_driver.sv
// Host-side sequencer for the ternary mat-vec core: resets and commands the
// core, streams weights and buffered activation vectors, captures results.
module ternary_stream_driver
    import ternary_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    ternary_stream_driver_if.master bus
);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       vcnt_r, vcnt_s;
    logic             mode_r, mode_s;
    logic [15:0]      wbuf_r [WORDS];

    logic [15:0]      drv_word_r, drv_word_s;
    logic             dut_rst_n_r, dut_rst_n_s;
    logic             act_ready_r, act_ready_s;
    logic             res_valid_r;
    logic [7:0]       res_data_r;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    logic             accept_s;
    logic             pop_s;
    logic             buf_full_s;
    logic             buf_empty_s;
    logic [15:0]      buf_rd_data_s;

    assign accept_s = bus.act_valid && act_ready_r && !buf_full_s;
    assign pop_s    = (state_s == S_SEND) && !buf_empty_s;

    ternary_vec_buf #(
        .DEPTH (VEC_WORDS),
        .W     (16)
    ) u_vec_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept_s),
        .wr_data (bus.act_data),
        .rd_en   (pop_s),
        .rd_data (buf_rd_data_s),
        .full    (buf_full_s),
        .empty   (buf_empty_s)
    );

    // Weight RAM: survives driver reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (bus.w_wr_en && (state_r == S_IDLE)) begin
            wbuf_r[bus.w_wr_addr] <= bus.w_wr_data;
        end
    end

    // Next-state and sequencing counters.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        vcnt_s  = vcnt_r;
        mode_s  = mode_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    mode_s  = bus.mode_load;
                    vcnt_s  = bus.vec_count;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = bus.mode_load ? S_RST : S_CMD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RST: begin
                if (cnt_r == RST_LAST) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = S_CMD;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            S_CMD: begin
                cnt_s = {CNT_W{1'b0}};
                if (mode_r) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = (vcnt_r == 8'd0) ? S_FIN : S_FILL;
                end
            end
            S_LOAD: begin
                if (cnt_r == LOAD_LAST) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = (vcnt_r == 8'd0) ? S_FIN : S_FILL;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            S_FILL: begin
                if (accept_s) begin
                    if (cnt_r == SEND_LAST) begin
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = S_SEND;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            S_SEND: begin
                if (cnt_r == SEND_LAST) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = S_WAIT;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_r == WAIT_LAST) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = S_CAPT;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            S_CAPT: begin
                if (cnt_r == CAPT_LAST) begin
                    cnt_s   = {CNT_W{1'b0}};
                    vcnt_s  = (vcnt_r == 8'd0) ? 8'd0 : vcnt_r - 8'd1;
                    state_s = (vcnt_r <= 8'd1) ? S_FIN : S_FILL;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            S_FIN: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Outputs are derived from the upcoming state so the registered values
    // line up cycle-for-cycle with state_r.
    always_comb begin
        drv_word_s = 16'h0000;
        case (state_s)
            S_CMD:   drv_word_s = cmd_word(mode_s ? CMD_LOAD : CMD_MULT);
            S_LOAD:  drv_word_s = wbuf_r[cnt_s[WA_W-1:0]];
            S_SEND:  drv_word_s = buf_rd_data_s;
            default: drv_word_s = 16'h0000;
        endcase
        dut_rst_n_s = (state_s != S_RST);
        act_ready_s = (state_s == S_FILL);
        busy_s      = (state_s != S_IDLE);
        done_s      = (state_s == S_FIN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            vcnt_r      <= 8'd0;
            mode_r      <= 1'b0;
            drv_word_r  <= 16'h0000;
            dut_rst_n_r <= 1'b1;
            act_ready_r <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= 8'h00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            vcnt_r      <= vcnt_s;
            mode_r      <= mode_s;
            drv_word_r  <= drv_word_s;
            dut_rst_n_r <= dut_rst_n_s;
            act_ready_r <= act_ready_s;
            res_valid_r <= (state_r == S_CAPT);
            res_data_r  <= (state_r == S_CAPT) ? bus.res_in : res_data_r;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign bus.drv_word  = drv_word_r;
    assign bus.dut_rst_n = dut_rst_n_r;
    assign bus.act_ready = act_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_ternary_stream_driver.sv
// Directed self-checking bench for ternary_stream_driver with a result
// scoreboard fed from the bench's own core-output model.
module tb_ternary_stream_driver;
    import ternary_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ternary_stream_driver_if bus();

    ternary_stream_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks     = 0;
    int errors     = 0;
    int res_pulses = 0;
    int r0         = 0;
    logic [15:0] act_q [$];
    logic [7:0]  res_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.res_in = bus.res_in + 8'd37;
    endtask

    task automatic wr_w(input int addr, input logic [15:0] data);
        bus.w_wr_en   = 1'b1;
        bus.w_wr_addr = WA_W'(addr);
        bus.w_wr_data = data;
        step();
        bus.w_wr_en   = 1'b0;
    endtask

    task automatic start_job(input logic ml, input logic [7:0] vc);
        bus.start     = 1'b1;
        bus.mode_load = ml;
        bus.vec_count = vc;
        step();
        bus.start     = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    // Entered with the driver in FILL; returns on the cycle after the last capture.
    task automatic run_vector(input logic [15:0] base, input bit gaps);
        int got = 0;
        int it  = 0;
        bit ph  = 1'b0;
        while (got < VEC_WORDS && it < 64) begin
            it++;
            bus.act_valid = gaps ? ph : 1'b1;
            ph = !ph;
            bus.act_data = base + 16'(got) * 16'h0202;
            if (bus.act_valid && bus.act_ready) begin
                act_q.push_back(bus.act_data);
                got++;
            end
            step();
        end
        bus.act_valid = 1'b0;
        chk("fill_words", 32'(got), 32'(VEC_WORDS));
        for (int k = 0; k < VEC_WORDS; k++) begin
            chk("send_word", 32'(bus.drv_word), 32'(act_q.pop_front()));
            chk("send_no_res", 32'(bus.res_valid), 32'd0);
            chk("send_not_ready", 32'(bus.act_ready), 32'd0);
            step();
        end
        chk("wait_word", 32'(bus.drv_word), 32'd0);
        step();
        for (int k = 0; k < OUT_LEN; k++) begin
            res_q.push_back(bus.res_in);
            step();
        end
    endtask

    // Result scoreboard: every res_valid pulse must match the next expected byte.
    always @(negedge clk) begin
        if (bus.res_valid === 1'b1) begin
            res_pulses++;
            if (res_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL res_unexpected observed=%0h expected=none", bus.res_data);
            end else begin
                chk("res_data", 32'(bus.res_data), 32'(res_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.mode_load = 1'b0;
        bus.vec_count = 8'd0;
        bus.w_wr_en   = 1'b0;
        bus.w_wr_addr = {WA_W{1'b0}};
        bus.w_wr_data = 16'h0000;
        bus.act_valid = 1'b0;
        bus.act_data  = 16'h0000;
        bus.res_in    = 8'h00;
        step();
        step();
        chk("rst_drv_word", 32'(bus.drv_word), 32'd0);
        chk("rst_dut_rst_n", 32'(bus.dut_rst_n), 32'd1);
        chk("rst_act_ready", 32'(bus.act_ready), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        step();

        // Load job, one vector, with start/w_wr_en poked while busy.
        for (int i = 0; i < WORDS; i++) wr_w(i, 16'h5555);
        r0 = res_pulses;
        start_job(1'b1, 8'd1);
        for (int s = 0; s < 2; s++) begin
            chk("rst_pulse_low", 32'(bus.dut_rst_n), 32'd0);
            chk("rst_pulse_word", 32'(bus.drv_word), 32'd0);
            step();
        end
        chk("cmd_load", 32'(bus.drv_word), 32'h2000);
        chk("cmd_rst_high", 32'(bus.dut_rst_n), 32'd1);
        step();
        for (int s = 0; s < WORDS; s++) begin
            chk("load_word", 32'(bus.drv_word), 32'h5555);
            if (s == 1) begin
                bus.start     = 1'b1;
                bus.mode_load = 1'b0;
                bus.vec_count = 8'd5;
                bus.w_wr_en   = 1'b1;
                bus.w_wr_addr = WA_W'(3);
                bus.w_wr_data = 16'hFFFF;
            end
            if (s == 4) begin
                bus.start   = 1'b0;
                bus.w_wr_en = 1'b0;
            end
            step();
        end
        chk("fill_ready", 32'(bus.act_ready), 32'd1);
        run_vector(16'h0A0B, 1'b0);
        chk("job1_done", 32'(bus.done), 32'd1);
        step();
        chk("job1_done_pulse", 32'(bus.done), 32'd0);
        chk("job1_idle", 32'(bus.busy), 32'd0);
        step();
        chk("job1_res_count", 32'(res_pulses - r0), 32'd8);
        chk("job1_no_rerun", 32'(bus.busy), 32'd0);

        // Multiply-only job, two vectors.
        r0 = res_pulses;
        start_job(1'b0, 8'd2);
        chk("cmd_mult", 32'(bus.drv_word), 32'h3000);
        step();
        chk("mult_fill1", 32'(bus.act_ready), 32'd1);
        run_vector(16'h0102, 1'b0);
        chk("mult_fill2", 32'(bus.act_ready), 32'd1);
        chk("mult_not_done", 32'(bus.done), 32'd0);
        run_vector(16'h1112, 1'b0);
        chk("mult_done", 32'(bus.done), 32'd1);
        step();
        chk("mult_idle", 32'(bus.busy), 32'd0);
        step();
        chk("mult_res_count", 32'(res_pulses - r0), 32'd16);
        chk("mult_res_drained", 32'(res_q.size()), 32'd0);

        // Multiply-only job with act_valid toggling every other cycle.
        start_job(1'b0, 8'd1);
        chk("cmd_mult_gap", 32'(bus.drv_word), 32'h3000);
        step();
        run_vector(16'h2122, 1'b1);
        chk("gap_done", 32'(bus.done), 32'd1);
        step();
        step();

        // Zero-vector load job; also confirms the busy-time write was dropped.
        r0 = res_pulses;
        start_job(1'b1, 8'd0);
        step();
        step();
        chk("zero_cmd", 32'(bus.drv_word), 32'h2000);
        step();
        for (int s = 0; s < WORDS; s++) begin
            chk("zero_load_word", 32'(bus.drv_word), 32'h5555);
            step();
        end
        chk("zero_done", 32'(bus.done), 32'd1);
        chk("zero_no_fill", 32'(bus.act_ready), 32'd0);
        step();
        chk("zero_idle", 32'(bus.busy), 32'd0);
        step();
        chk("zero_res_count", 32'(res_pulses - r0), 32'd0);

        // Driver reset during LOAD word 5.
        for (int i = 0; i < WORDS; i++) wr_w(i, 16'hA000 + 16'(i));
        start_job(1'b1, 8'd1);
        step();
        step();
        step();
        for (int s = 0; s < 5; s++) begin
            chk("abort_load_word", 32'(bus.drv_word), 32'hA000 + 32'(s));
            step();
        end
        chk("abort_word5", 32'(bus.drv_word), 32'hA005);
        rst_n = 1'b0;
        step();
        chk("abort_drv_word", 32'(bus.drv_word), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_dut_rst_n", 32'(bus.dut_rst_n), 32'd1);
        chk("abort_act_ready", 32'(bus.act_ready), 32'd0);
        chk("abort_res_valid", 32'(bus.res_valid), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        step();
        step();
        chk("abort_stays_idle", 32'(bus.busy), 32'd0);
        start_job(1'b0, 8'd0);
        chk("post_abort_cmd", 32'(bus.drv_word), 32'h3000);
        step();
        chk("post_abort_done", 32'(bus.done), 32'd1);
        step();
        chk("post_abort_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
